round_ctl: RTL and testbench
============================

# round_ctl

Game-round sequencer for the duck playfield. It releases ducks one at a time into the duck flight controller through its reset line, and counts the player's shots per duck. It decides per duck whether it is hit, escapes on timeout, or escapes after the last bullet, and advances rounds or ends the game on the hit tally. It sits between trigger/hit detection and the duck controller, clocked on the animation clock.

## Interface

**Parameters**
- `DUCKS`, default 10: ducks per round, range 1..15.
- `SHOTS`, default 3: bullets per duck, range 1..3.
- `TIMEOUT`, default 200: aclk ticks a duck may fly before escaping, range 1..255.
- `ESC_TICKS`, default 40: aclk ticks in the fly-away phase, range 1..255.
- `INTRO_TICKS`, default 60: aclk ticks of the pre-round pause, range 1..255.
- `PASS_HITS`, default 6: hits needed to advance a round, range 0..DUCKS.

**Ports**
- `aclk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that starts a game.
- `fire` in 1: one-cycle trigger pulse.
- `hit` in 1: one-cycle pulse meaning the current duck was hit by this cycle's shot.
- `duck_down` in 1: level; high when the falling duck has landed.
- `duck_rst` out 1: drives the duck controller's reset. High means the duck is parked.
- `shots_left` out 2: bullets remaining for the current duck.
- `duck_idx` out 4: index of the current duck, 0..DUCKS-1.
- `hits` out 4: hits so far in this round.
- `hit_mask` out DUCKS: bit i set means duck i was hit.
- `round` out 8: round number, 1-based, saturates at 255.
- `state` out 3: current FSM state.
- `fly_away` out 1: high during the escape phase.
- `game_over` out 1: high in OVER.

## Operation

**States** (the encoding is the `state` value)
- **IDLE=0**: `duck_rst`=1. On `start`, set `round`=1 and go to INTRO.
- **INTRO=1**: `duck_rst`=1. Clear `duck_idx`, `hits` and `hit_mask`. Count `INTRO_TICKS` cycles, then go to FLY. On entry to FLY, load `shots_left`=SHOTS and clear the timer.
- **FLY=2**: `duck_rst`=0.
  - If `fire` and `shots_left`>0, decrement `shots_left`.
  - `fire` with `shots_left`=0 is ignored.
  - If `hit`: increment `hits`, set `hit_mask[duck_idx]`, and go to FALL.
  - Otherwise, if the timer reaches TIMEOUT-1, or `shots_left`=0 at the start of the cycle, go to ESCAPE.
  - Precedence is hit > timeout = out-of-shots.
  - A `hit` in the same cycle as the last `fire` counts as a hit.
- **FALL=3**: `duck_rst`=0. Wait for `duck_down`=1, then go to NEXT.
- **ESCAPE=4**: `duck_rst`=0 and `fly_away`=1 for `ESC_TICKS` cycles, then go to NEXT.
- **NEXT=5**: a single cycle with `duck_rst`=1, which re-centres the duck.
  - If `duck_idx`=DUCKS-1, go to TALLY.
  - Otherwise increment `duck_idx`, reload `shots_left`=SHOTS, clear the timer, and go to FLY.
- **TALLY=6**: a single cycle.
  - If `hits`≥PASS_HITS, increment `round` (saturating at 255) and go to INTRO.
  - Otherwise go to OVER.
- **OVER=7**: `duck_rst`=1, `game_over`=1. On `start`, set `round`=1 and go to INTRO.

**Ignored inputs**
- `fire` and `hit` are ignored outside FLY.
- `start` is ignored outside IDLE and OVER.
- `duck_down` is ignored outside FALL.

**Widths and counters**
- The timer and phase counters are 8-bit.
- `hits` never exceeds DUCKS, so it never wraps.

## Timing

**Registers and latency**
- All outputs are registered; there are no combinational paths from input to output.
- An event sampled at edge N shows on the outputs after edge N.
- `duck_rst` falls on the same edge that `state` becomes FLY.

**Reset**
- `rst` has priority over every input and applies at the next edge.
- Reset values: `state`=IDLE, `duck_rst`=1, `shots_left`=0, `duck_idx`=0, `hits`=0, `hit_mask`=0, `round`=0, `fly_away`=0, `game_over`=0.
- A reset mid-flight or mid-fall drops straight to IDLE with no TALLY.

**Phase durations**
- INTRO lasts exactly `INTRO_TICKS` cycles.
- FLY times out after exactly `TIMEOUT` cycles if there is no hit and there are bullets left.
- ESCAPE lasts exactly `ESC_TICKS` cycles.
- NEXT and TALLY last 1 cycle each.

**Simultaneous events and boundaries**
- `fire` and `hit` in the same FLY cycle: `shots_left` is decremented and the duck is counted as hit.
- Timeout and `hit` in the same cycle: hit wins.
- Running out of shots: ESCAPE is entered the cycle after the last `fire`, if that last shot had no `hit`.

## Test plan

Parameters for scenarios 1–3: DUCKS=2, SHOTS=3, TIMEOUT=10, ESC_TICKS=4, INTRO_TICKS=3, PASS_HITS=1.

1. **Reset values.** Hold `rst` for 2 cycles -> all outputs at their reset values and `state`=0. Then pulse `start` -> `round`=1, `state`=1 for 3 cycles, then `state`=2 with `duck_rst`=0 and `shots_left`=3.
2. **Hit path.** In FLY, assert `fire`+`hit` together -> `shots_left`=2, `hits`=1, `hit_mask`=01, `state`=3. Raise `duck_down` -> NEXT with one cycle of `duck_rst`=1, then FLY with `duck_idx`=1 and `shots_left`=3.
3. **Miss out of shots.** Pulse `fire` 3 times with no `hit` -> `shots_left`=0, then ESCAPE with `fly_away`=1 for 4 cycles, then NEXT and TALLY. With `hits`=1, `round` becomes 2 and `state`=1.
4. **Timeout.** No `fire` for 10 FLY cycles -> ESCAPE. A `hit` on cycle 10 instead -> FALL.
5. **Fail round.** With PASS_HITS=2 and only 1 hit -> TALLY goes to OVER and `game_over`=1. `fire`, `hit` and `duck_down` are ignored there. `start` -> `round`=1 and INTRO.
6. **Reset mid-operation.** Assert `rst` while in FALL with `hits`=1 -> next cycle `state`=0, `hits`=0, `hit_mask`=0, `duck_rst`=1.

Source files
------------

// File: rtl/round_ctl.sv
// Round sequencer for the duck playfield: releases ducks one at a time, counts shots,
// decides hit / timeout / out-of-ammo per duck and advances rounds on the hit tally.
module round_ctl #(
    parameter int DUCKS       = 10,
    parameter int SHOTS       = 3,
    parameter int TIMEOUT     = 200,
    parameter int ESC_TICKS   = 40,
    parameter int INTRO_TICKS = 60,
    parameter int PASS_HITS   = 6
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             start,
    input  logic             fire,
    input  logic             hit,
    input  logic             duck_down,
    output logic             duck_rst,
    output logic [1:0]       shots_left,
    output logic [3:0]       duck_idx,
    output logic [3:0]       hits,
    output logic [DUCKS-1:0] hit_mask,
    output logic [7:0]       round,
    output logic [2:0]       state,
    output logic             fly_away,
    output logic             game_over
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INTRO  = 3'd1,
        S_FLY    = 3'd2,
        S_FALL   = 3'd3,
        S_ESCAPE = 3'd4,
        S_NEXT   = 3'd5,
        S_TALLY  = 3'd6,
        S_OVER   = 3'd7
    } state_t;

    localparam logic [7:0] INTRO_LAST = 8'(INTRO_TICKS - 1);
    localparam logic [7:0] FLY_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] ESC_LAST   = 8'(ESC_TICKS - 1);
    localparam logic [1:0] SHOTS_Q    = 2'(SHOTS);
    localparam logic [3:0] LAST_DUCK  = 4'(DUCKS - 1);
    localparam logic [3:0] PASS_Q     = 4'(PASS_HITS);

    state_t           state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [1:0]       shots_q, shots_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       hits_q, hits_d;
    logic [DUCKS-1:0] mask_q, mask_d;
    logic [7:0]       round_q, round_d;
    logic             duck_rst_q, duck_rst_d;
    logic             fly_away_q, fly_away_d;
    logic             game_over_q, game_over_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    // State register
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; phase_q counts cycles spent in the current state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_INTRO; else state_d = state_q;
            S_INTRO:        if (phase_q == INTRO_LAST) state_d = S_FLY; else state_d = state_q;
            S_FLY: begin
                if (hit) begin
                    state_d = S_FALL;
                end else if (phase_q == FLY_LAST || shots_q == 2'd0) begin
                    state_d = S_ESCAPE;
                end else begin
                    state_d = state_q;
                end
            end
            S_FALL:   if (duck_down) state_d = S_NEXT; else state_d = state_q;
            S_ESCAPE: if (phase_q == ESC_LAST) state_d = S_NEXT; else state_d = state_q;
            S_NEXT:   if (idx_q == LAST_DUCK) state_d = S_TALLY; else state_d = S_FLY;
            S_TALLY:  if (hits_q >= PASS_Q) state_d = S_INTRO; else state_d = S_OVER;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state, so the flops change on the same edge as state
    always_comb begin
        duck_rst_d  = 1'b1;
        fly_away_d  = 1'b0;
        game_over_d = 1'b0;
        case (state_d)
            S_FLY, S_FALL: duck_rst_d = 1'b0;
            S_ESCAPE: begin
                duck_rst_d = 1'b0;
                fly_away_d = 1'b1;
            end
            S_OVER:  game_over_d = 1'b1;
            default: duck_rst_d = 1'b1;
        endcase
    end

    // Datapath next values: per-round tallies clear on INTRO entry, ammo reloads on FLY entry
    always_comb begin
        shots_d = shots_q;
        idx_d   = idx_q;
        hits_d  = hits_q;
        mask_d  = mask_q;
        round_d = round_q;
        if (state_d != state_q) phase_d = 8'd0; else phase_d = phase_q + 8'd1;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    round_d = 8'd1;
                    idx_d   = 4'd0;
                    hits_d  = 4'd0;
                    mask_d  = '0;
                end else begin
                    round_d = round_q;
                end
            end
            S_INTRO: if (state_d == S_FLY) shots_d = SHOTS_Q; else shots_d = shots_q;
            S_FLY: begin
                if (fire && shots_q != 2'd0) shots_d = shots_q - 2'd1; else shots_d = shots_q;
                if (hit) begin
                    hits_d = hits_q + 4'd1;
                    mask_d = mask_q | (DUCKS'(1'b1) << idx_q);
                end else begin
                    hits_d = hits_q;
                    mask_d = mask_q;
                end
            end
            S_NEXT: begin
                if (state_d == S_FLY) begin
                    idx_d   = idx_q + 4'd1;
                    shots_d = SHOTS_Q;
                end else begin
                    idx_d = idx_q;
                end
            end
            S_TALLY: begin
                if (state_d == S_INTRO) begin
                    round_d = sat_inc8(round_q);
                    idx_d   = 4'd0;
                    hits_d  = 4'd0;
                    mask_d  = '0;
                end else begin
                    round_d = round_q;
                end
            end
            default: round_d = round_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge aclk) begin
        if (rst) begin
            phase_q     <= 8'd0;
            shots_q     <= 2'd0;
            idx_q       <= 4'd0;
            hits_q      <= 4'd0;
            mask_q      <= '0;
            round_q     <= 8'd0;
            duck_rst_q  <= 1'b1;
            fly_away_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            shots_q     <= shots_d;
            idx_q       <= idx_d;
            hits_q      <= hits_d;
            mask_q      <= mask_d;
            round_q     <= round_d;
            duck_rst_q  <= duck_rst_d;
            fly_away_q  <= fly_away_d;
            game_over_q <= game_over_d;
        end
    end

    assign state      = state_q;
    assign duck_rst   = duck_rst_q;
    assign shots_left = shots_q;
    assign duck_idx   = idx_q;
    assign hits       = hits_q;
    assign hit_mask   = mask_q;
    assign round      = round_q;
    assign fly_away   = fly_away_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_round_ctl.sv
// Bench for round_ctl: directed vector table, hand sequences for timing corners,
// and random stimulus against a countdown-based reference model (two PASS_HITS variants).
module tb_round_ctl;

    localparam int DUCKS   = 2;
    localparam int SHOTS   = 3;
    localparam int TIMEOUT = 10;
    localparam int ESC     = 4;
    localparam int INTRO   = 3;

    logic aclk = 1'b0;
    logic rst = 1'b0, start = 1'b0, fire = 1'b0, hit = 1'b0, duck_down = 1'b0;

    logic       d1_duck_rst, d1_fly_away, d1_game_over;
    logic [1:0] d1_shots_left, d1_hit_mask;
    logic [3:0] d1_duck_idx, d1_hits;
    logic [7:0] d1_round;
    logic [2:0] d1_state;
    logic       d2_duck_rst, d2_fly_away, d2_game_over;
    logic [1:0] d2_shots_left, d2_hit_mask;
    logic [3:0] d2_duck_idx, d2_hits;
    logic [7:0] d2_round;
    logic [2:0] d2_state;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    round_ctl #(.DUCKS(DUCKS), .SHOTS(SHOTS), .TIMEOUT(TIMEOUT), .ESC_TICKS(ESC),
                .INTRO_TICKS(INTRO), .PASS_HITS(1)) u_dut1 (
        .aclk(aclk), .rst(rst), .start(start), .fire(fire), .hit(hit), .duck_down(duck_down),
        .duck_rst(d1_duck_rst), .shots_left(d1_shots_left), .duck_idx(d1_duck_idx),
        .hits(d1_hits), .hit_mask(d1_hit_mask), .round(d1_round), .state(d1_state),
        .fly_away(d1_fly_away), .game_over(d1_game_over)
    );

    round_ctl #(.DUCKS(DUCKS), .SHOTS(SHOTS), .TIMEOUT(TIMEOUT), .ESC_TICKS(ESC),
                .INTRO_TICKS(INTRO), .PASS_HITS(2)) u_dut2 (
        .aclk(aclk), .rst(rst), .start(start), .fire(fire), .hit(hit), .duck_down(duck_down),
        .duck_rst(d2_duck_rst), .shots_left(d2_shots_left), .duck_idx(d2_duck_idx),
        .hits(d2_hits), .hit_mask(d2_hit_mask), .round(d2_round), .state(d2_state),
        .fly_away(d2_fly_away), .game_over(d2_game_over)
    );

    logic [25:0] p1, p2;
    assign p1 = {d1_state, d1_duck_rst, d1_shots_left, d1_duck_idx, d1_hits, d1_hit_mask,
                 d1_round, d1_fly_away, d1_game_over};
    assign p2 = {d2_state, d2_duck_rst, d2_shots_left, d2_duck_idx, d2_hits, d2_hit_mask,
                 d2_round, d2_fly_away, d2_game_over};

    // Reference model: each timed phase holds the number of cycles still to spend in it
    typedef struct {
        int st;
        int left;
        int shots;
        int idx;
        int hits;
        int mask;
        int rnd;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t to_intro(mdl_t m);
        mdl_t n = m;
        n.st = 1; n.left = INTRO; n.idx = 0; n.hits = 0; n.mask = 0;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [4:0] in, int pass);
        mdl_t n = m;
        if (in[4]) begin
            n = '{0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        case (m.st)
            0, 7: if (in[3]) begin n.rnd = 1; n = to_intro(n); end
            1: if (m.left == 1) begin n.st = 2; n.shots = SHOTS; n.left = TIMEOUT; end
               else n.left = m.left - 1;
            2: begin
                if (in[2] && m.shots > 0) n.shots = m.shots - 1;
                if (in[1]) begin
                    n.hits = m.hits + 1; n.mask = m.mask | (1 << m.idx); n.st = 3;
                end else if (m.left == 1 || m.shots == 0) begin
                    n.st = 4; n.left = ESC;
                end else n.left = m.left - 1;
            end
            3: if (in[0]) n.st = 5;
            4: if (m.left == 1) n.st = 5; else n.left = m.left - 1;
            5: if (m.idx == DUCKS - 1) n.st = 6;
               else begin n.idx = m.idx + 1; n.shots = SHOTS; n.st = 2; n.left = TIMEOUT; end
            6: if (m.hits >= pass) begin
                   n.rnd = (m.rnd < 255) ? m.rnd + 1 : 255; n = to_intro(n);
               end else n.st = 7;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    function automatic logic [25:0] mpack(mdl_t m);
        logic drst = (m.st <= 1) || (m.st >= 5);
        return {3'(m.st), drst, 2'(m.shots), 4'(m.idx), 4'(m.hits), 2'(m.mask), 8'(m.rnd),
                (m.st == 4), (m.st == 7)};
    endfunction

    typedef struct {
        logic [4:0] in;  // {rst, start, fire, hit, duck_down}
        int st; int drst; int shots; int idx; int hits; int mask; int rnd; int fly; int over;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [25:0] vpack(vec_t v);
        return {3'(v.st), 1'(v.drst), 2'(v.shots), 4'(v.idx), 4'(v.hits), 2'(v.mask),
                8'(v.rnd), 1'(v.fly), 1'(v.over)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [4:0] in);
        {rst, start, fire, hit, duck_down} = in;
        @(posedge aclk);
        m1 = mstep(m1, in, 1);
        m2 = mstep(m2, in, 2);
        #1;
        chk("model_pass1", 32'(p1), 32'(mpack(m1)));
        chk("model_pass2", 32'(p2), 32'(mpack(m2)));
        {rst, start, fire, hit, duck_down} = 5'b00000;
    endtask

    initial begin
        logic [4:0] rin;
        m1 = '{0, 0, 0, 0, 0, 0, 0};
        m2 = '{0, 0, 0, 0, 0, 0, 0};
        //           in         st dr sh ix ht mk rd fl ov
        tbl[0]  = '{5'b10000, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{5'b10000, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{5'b01000, 1, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{5'b01000, 1, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{5'b00111, 1, 1, 0, 0, 0, 0, 1, 0, 0};
        tbl[5]  = '{5'b00000, 2, 0, 3, 0, 0, 0, 1, 0, 0};
        tbl[6]  = '{5'b00110, 3, 0, 2, 0, 1, 1, 1, 0, 0};
        tbl[7]  = '{5'b00110, 3, 0, 2, 0, 1, 1, 1, 0, 0};
        tbl[8]  = '{5'b00001, 5, 1, 2, 0, 1, 1, 1, 0, 0};
        tbl[9]  = '{5'b00000, 2, 0, 3, 1, 1, 1, 1, 0, 0};
        tbl[10] = '{5'b00100, 2, 0, 2, 1, 1, 1, 1, 0, 0};
        tbl[11] = '{5'b00100, 2, 0, 1, 1, 1, 1, 1, 0, 0};
        tbl[12] = '{5'b00100, 2, 0, 0, 1, 1, 1, 1, 0, 0};
        tbl[13] = '{5'b00100, 4, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[14] = '{5'b00000, 4, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[15] = '{5'b00000, 4, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[16] = '{5'b00000, 4, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[17] = '{5'b00000, 5, 1, 0, 1, 1, 1, 1, 0, 0};
        tbl[18] = '{5'b00000, 6, 1, 0, 1, 1, 1, 1, 0, 0};
        tbl[19] = '{5'b00000, 1, 1, 0, 0, 0, 0, 2, 0, 0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d", i), 32'(p1), 32'(vpack(tbl[i])));
        end

        // PASS_HITS=2 copy failed the round with a single hit
        chk("over_entry", 32'({d2_state, d2_game_over, d2_duck_rst, d2_round, d2_hits}),
            32'({3'd7, 1'b1, 1'b1, 8'd1, 4'd1}));
        step(5'b00111);
        chk("over_ignores", 32'({d2_state, d2_hits, d2_hit_mask, d2_shots_left}),
            32'({3'd7, 4'd1, 2'b01, 2'd0}));
        step(5'b00000);
        step(5'b00000);
        chk("fly_entry_r2", 32'({d1_state, d1_duck_rst, d1_shots_left, d1_round}),
            32'({3'd2, 1'b0, 2'd3, 8'd2}));

        for (int i = 0; i < 9; i++) begin
            step((i == 2) ? 5'b01000 : 5'b00000);
            if (i == 2) begin
                chk("restart_from_over", 32'({d2_state, d2_round, d2_game_over, d2_hits, d2_hit_mask}),
                    32'({3'd1, 8'd1, 1'b0, 4'd0, 2'b00}));
                chk("start_ignored_in_fly", 32'(d1_state), 32'(3'd2));
            end
        end
        chk("fly_10th_cycle", 32'(d1_state), 32'(3'd2));
        step(5'b00000);
        chk("timeout", 32'({d1_state, d1_fly_away, d1_duck_rst}), 32'({3'd4, 1'b1, 1'b0}));
        for (int i = 0; i < 3; i++) step(5'b00000);
        chk("escape_4th_cycle", 32'(d1_state), 32'(3'd4));
        step(5'b00000);
        chk("next_after_escape", 32'({d1_state, d1_duck_rst, d1_fly_away}), 32'({3'd5, 1'b1, 1'b0}));
        step(5'b00000);
        chk("fly_duck1", 32'({d1_state, d1_duck_idx, d1_shots_left, d1_duck_rst}),
            32'({3'd2, 4'd1, 2'd3, 1'b0}));
        for (int i = 0; i < 9; i++) step(5'b00000);
        step(5'b00010);
        chk("hit_beats_timeout", 32'({d1_state, d1_hits, d1_hit_mask}), 32'({3'd3, 4'd1, 2'b10}));
        step(5'b10000);
        chk("reset_mid_fall", 32'({d1_state, d1_hits, d1_hit_mask, d1_duck_rst, d1_round,
                                   d1_shots_left, d1_duck_idx}),
            32'({3'd0, 4'd0, 2'b00, 1'b1, 8'd0, 2'd0, 4'd0}));

        // Fast hit-every-duck loop to drive the round counter into saturation
        step(5'b01000);
        for (int i = 0; i < 2700; i++) step(5'b00111);
        chk("round_saturates", 32'(d1_round), 32'(8'd255));

        step(5'b10000);
        for (int i = 0; i < 4000; i++) begin
            rin[4] = ($urandom_range(0, 199) == 0);
            rin[3] = ($urandom_range(0, 3) == 0);
            rin[2] = ($urandom_range(0, 2) == 0);
            rin[1] = ($urandom_range(0, 5) == 0);
            rin[0] = ($urandom_range(0, 2) == 0);
            step(rin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
